// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register file write side.
package regfile_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } regfile_wr_state_t;

  localparam logic [REG_ADDR_W-1:0] CLEAR_FIRST = 5'd1;
  localparam logic [REG_ADDR_W-1:0] CLEAR_LAST  = 5'd31;

endpackage

// File: rtl/regfile_write_port_decoder.sv
// 5-bit index to 32-bit one-hot decoder; all zeros when disabled.
module decoder5to32
  import regfile_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] idx,
  output logic [REG_COUNT-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (en && (idx == REG_ADDR_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry register file: handshaked writes, r0 hardwired
// to zero, sequential bulk clear of r1..r31, flattened read bus.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]          wr_data,
  output logic                  wr_ack,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [REG_COUNT*N-1:0] regs
);

  regfile_wr_state_t     state;
  logic [REG_ADDR_W-1:0] cnt;
  logic [N-1:0]          r [1:REG_COUNT-1];
  logic [REG_COUNT-1:0]  we;
  logic                  accept;
  logic                  unused_we0;

  assign wr_ready = (state == S_IDLE);
  assign busy     = (state == S_CLEAR);
  assign accept   = wr_valid && wr_ready;

  decoder5to32 u_dec (
    .en     (accept),
    .idx    (wr_addr),
    .onehot (we)
  );

  // r0 has no storage; its enable is decoded but intentionally dropped.
  assign unused_we0 = we[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= accept;
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            state <= S_CLEAR;
            cnt   <= CLEAR_FIRST;
          end
        end
        S_CLEAR: begin
          if (cnt == CLEAR_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Writes only land in IDLE and clearing only happens in CLEAR, so the two
  // paths never target a register on the same edge.
  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      if (!rst) begin
        r[i] <= '0;
      end else if (we[i]) begin
        r[i] <= wr_data;
      end else if ((state == S_CLEAR) && (cnt == REG_ADDR_W'(i))) begin
        r[i] <= '0;
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      regs[i*N +: N] = r[i];
    end
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port with a cycle-level reference model.
module tb_regfile_write_port;

  localparam int unsigned N = 32;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_addr;
  logic [N-1:0]  wr_data;
  logic          wr_ack;
  logic          clear_req;
  logic          busy;
  logic [32*N-1:0] regs;

  int checks = 0;
  int errors = 0;

  regfile_write_port #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .clear_req (clear_req),
    .busy      (busy),
    .regs      (regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register array plus "clear in progress, next index".
  logic [N-1:0] m [32];
  bit           m_clearing;
  int           m_pos;
  bit           m_ack;
  bit           started = 0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      m_clearing = 0;
      m_pos      = 0;
      m_ack      = 0;
      started    = 1;
    end else begin
      m_ack = wr_valid && !m_clearing;
      if (m_ack && wr_addr != 0) m[wr_addr] = wr_data;
      if (m_clearing) begin
        m[m_pos] = '0;
        if (m_pos == 31) m_clearing = 0;
        else m_pos = m_pos + 1;
      end else if (clear_req) begin
        m_clearing = 1;
        m_pos      = 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("wr_ready", 64'(wr_ready), 64'(!m_clearing));
      check("busy", 64'(busy), 64'(m_clearing));
      check("wr_ack", 64'(wr_ack), 64'(m_ack));
      for (int i = 0; i < 32; i++) begin
        check($sformatf("regs[%0d]", i), 64'(regs[i*N +: N]), 64'(m[i]));
      end
    end
  end

  task automatic do_write(input logic [4:0] a, input logic [N-1:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  int busy_cycles;

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("lit_ready_after_reset", 64'(wr_ready), 64'd1);
    check("lit_regs_after_reset", 64'(|regs), 64'd0);

    // Basic write
    do_write(5'd5, 32'hDEADBEEF);
    check("lit_r5", 64'(regs[5*N +: N]), 64'hDEADBEEF);
    check("lit_ack_pulse", 64'(wr_ack), 64'd1);
    @(negedge clk);
    check("lit_ack_drop", 64'(wr_ack), 64'd0);

    // r0 protection and top address
    do_write(5'd0, 32'hFFFFFFFF);
    check("lit_r0_ack", 64'(wr_ack), 64'd1);
    check("lit_r0_zero", 64'(regs[N-1:0]), 64'd0);
    do_write(5'd31, 32'h1);
    check("lit_r31", 64'(regs[31*N +: N]), 64'd1);

    // Back-to-back writes
    @(negedge clk);
    wr_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_addr = 5'(i);
      wr_data = N'(9 + i);
      @(negedge clk);
      check("lit_b2b_ack", 64'(wr_ack), 64'd1);
    end
    wr_valid = 1'b0;
    check("lit_r4", 64'(regs[4*N +: N]), 64'd13);

    // Fill 1..31, then clear with a write held throughout
    @(negedge clk);
    wr_valid = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wr_addr = 5'(i);
      wr_data = N'(i) * 32'h01010101;
      @(negedge clk);
    end
    wr_valid  = 1'b0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wr_valid  = 1'b1;
    wr_addr   = 5'd9;
    wr_data   = 32'd77;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("lit_busy_cycles", 64'(busy_cycles), 64'd31);
    @(negedge clk);
    check("lit_held_write_ack", 64'(wr_ack), 64'd1);
    check("lit_held_write_r9", 64'(regs[9*N +: N]), 64'd77);
    wr_valid = 1'b0;

    // Simultaneous write and clear
    @(negedge clk);
    wr_valid  = 1'b1;
    wr_addr   = 5'd7;
    wr_data   = 32'd55;
    clear_req = 1'b1;
    @(negedge clk);
    wr_valid  = 1'b0;
    clear_req = 1'b0;
    check("lit_sim_ack", 64'(wr_ack), 64'd1);
    check("lit_sim_r7", 64'(regs[7*N +: N]), 64'd55);
    wait_idle("sim_clear_done");
    check("lit_sim_r7_cleared", 64'(regs[7*N +: N]), 64'd0);

    // Reset mid-clear
    @(negedge clk);
    wr_valid = 1'b1;
    for (int i = 11; i < 32; i++) begin
      wr_addr = 5'(i);
      wr_data = 32'hA5A50000 + N'(i);
      @(negedge clk);
    end
    wr_valid  = 1'b0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("lit_rst_busy", 64'(busy), 64'd0);
    check("lit_rst_ready", 64'(wr_ready), 64'd1);
    check("lit_rst_regs", 64'(|regs), 64'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32-entry register file. It is the counterpart to the 32:1 read multiplexers.
- Accepts write requests over a valid/ready handshake and decodes the 5-bit address to a one-hot write enable.
- Holds 32 N-bit registers. Register 0 is hardwired to zero.
- Exposes every register on a flattened bus that feeds the read-side muxes. Also provides a sequential bulk-clear operation.

Parameters:
- N, 32, width of each register in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (register file resets when rst is 0 at a rising clk edge).
- wr_valid  input  1  write request present.
- wr_ready  output  1  port can accept a write this cycle.
- wr_addr  input  5  destination register index.
- wr_data  input  N  value to write.
- wr_ack  output  1  one-cycle pulse, registered, one cycle after an accepted write.
- clear_req  input  1  request to zero registers 1..31.
- busy  output  1  a clear sequence is in progress.
- regs  output  32*N  all registers; register i at bits [i*N +: N].

Behaviour:
- Reset (rst==0 at posedge clk): all 32 registers = 0, state = IDLE, clear counter = 0, wr_ack = 0, busy = 0. Reset overrides everything, including mid-clear (sequence aborted; all registers zero the next cycle).
- States: IDLE and CLEAR.
- wr_ready = (state == IDLE). It is purely a function of state and never depends on wr_valid or clear_req.
- busy = (state == CLEAR).
- Accept: wr_valid && wr_ready at posedge.
  - On that edge, reg[wr_addr] <= wr_data.
  - The new value is visible on regs in the following cycle (latency 1).
  - wr_ack = 1 for exactly the following cycle.
  - Back-to-back accepts are allowed every cycle; wr_ack then stays high continuously.
- Address 0: the write is accepted and acked, but reg[0] stays 0. regs[N-1:0] is constant 0 at all times.
- Write decode: only the one-hot selected register's enable is asserted; all other registers hold.
- IDLE with clear_req=1 at posedge:
  - Enter CLEAR with counter = 1.
  - If wr_valid is also high on the same edge, the write is still accepted and performed, and wr_ack pulses. The clear then zeroes that register in turn.
- CLEAR: each cycle, reg[counter] <= 0 and counter increments.
  - When counter == 31, zero reg[31] and return to IDLE on that edge.
  - busy is high for exactly 31 cycles. wr_ready is low for those same 31 cycles.
  - clear_req is ignored in CLEAR. wr_valid is not accepted; the requester must hold the request.
- Counter width is 5 bits and never wraps. The CLEAR exit condition is counter == 31.
- Data width is exactly N. There is no truncation or extension; wr_data is stored verbatim.

Decomposition:
- Package regfile_pkg:
  - REG_COUNT = 32.
  - REG_ADDR_W = 5.
  - State enum regfile_wr_state_t {S_IDLE, S_CLEAR}, 1 bit wide.
- Sub-module decoder5to32:
  - Inputs: 5-bit index and an enable.
  - Output: 32-bit one-hot vector, all zeros when the enable is low.
  - Used once for write enables; the clear path indexes reg[counter] directly.

Test Plan:
- Reset then write: hold rst=0 two cycles, release. Write addr 5, data 32'hDEADBEEF. Required: wr_ready=1; regs[5] = DEADBEEF one cycle later; wr_ack high for one cycle; all other registers 0.
- Register 0 protection: write addr 0, data 32'hFFFFFFFF. Required: wr_ack pulses and regs[0] stays 0. Then write addr 31, data 32'h1. Required: regs[31] = 1.
- Back-to-back writes: write addr 1..4 with data 10..13 on consecutive cycles. Required: wr_ack high 4 consecutive cycles; registers 1..4 end as 10..13.
- Clear sequence: fill registers 1..31 with nonzero values, pulse clear_req. Required:
  - busy=1 and wr_ready=0 for exactly 31 cycles.
  - Register k reads 0 starting k cycles after the request edge.
  - A wr_valid held during CLEAR is accepted on the first cycle after busy drops.
- Simultaneous write and clear: in IDLE, assert wr_valid (addr 7, data 55) and clear_req together. Required: wr_ack pulses; regs[7] = 55 briefly, then 0 after step 7; the clear completes normally.
- Reset mid-clear: start a clear and assert rst=0 at step 10. Required: next cycle busy=0, wr_ready=1, and all registers 0 (including 11..31, which had not yet been cleared).
